// File: rtl/picorv32_mem_responder.sv
// Word-addressed RAM responder for the picorv32 native memory bus with wait states and error flags.
// Define PICORV32_MEM_RESPONDER_RANDOM_WAIT_EN for LFSR-driven random wait states.
module picorv32_mem_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1,
  parameter int          MAX_WAIT  = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_valid,
  input  logic             mem_instr,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  input  logic             init_we,
  input  logic [31:0]      init_addr,
  input  logic [31:0]      init_data,
  output logic             bus_error,
  output logic             proto_error,
  output logic [CNT_W-1:0] xfer_count,
  output logic [CNT_W-1:0] fetch_count
);
  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       w_q, w_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             instr_q, instr_d;
  logic [CNT_W-1:0] xfer_q, xfer_d, fetch_q, fetch_d;
  logic             bus_err_q, bus_err_d, proto_q, proto_d;
  logic             ready_q;
  logic [31:0]      rdata_q;
  logic [3:0]       wait_init;
  logic             acc, core_we;

  logic [3:0][7:0]  mem [MEM_WORDS];

  // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both ends.
  function automatic logic addr_err(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a[1:0] != 2'b00) || (off >= SPAN);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[AW+1:2];
  endfunction

  assign acc = (state_q == IDLE) && mem_valid;

`ifdef PICORV32_MEM_RESPONDER_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (!resetn)  lfsr_q <= LFSR_SEED;
    else if (acc) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign wait_init = lfsr_q[3:0] & 4'(MAX_WAIT);
`else
  assign wait_init = 4'(LATENCY);
`endif

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    instr_d   = instr_q;
    xfer_d    = xfer_q;
    fetch_d   = fetch_q;
    bus_err_d = bus_err_q;
    proto_d   = proto_q;
    core_we   = 1'b0;
    case (state_q)
      IDLE: if (mem_valid) begin
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        wstrb_d = mem_wstrb;
        instr_d = mem_instr;
        w_d     = wait_init;
        state_d = (wait_init == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        if (!mem_valid) begin
          state_d = IDLE;
          proto_d = 1'b1;
        end else if (w_q == 4'd1) begin
          w_d     = 4'd0;
          state_d = RESP;
        end else begin
          w_d = w_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        // A request withdrawn in its response cycle is treated as never completed.
        if (!mem_valid) begin
          proto_d = 1'b1;
        end else begin
          xfer_d    = xfer_q + 1'b1;
          fetch_d   = fetch_q + CNT_W'(instr_q);
          bus_err_d = bus_err_q | addr_err(addr_q);
          core_we   = !addr_err(addr_q) && (wstrb_q != 4'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      w_q       <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      instr_q   <= 1'b0;
      xfer_q    <= '0;
      fetch_q   <= '0;
      bus_err_q <= 1'b0;
      proto_q   <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      instr_q   <= instr_d;
      xfer_q    <= xfer_d;
      fetch_q   <= fetch_d;
      bus_err_q <= bus_err_d;
      proto_q   <= proto_d;
      ready_q   <= (state_d == RESP);
      if (state_d == RESP && wstrb_d == 4'd0)
        rdata_q <= addr_err(addr_d) ? 32'hDEAD_BEEF : mem[word_idx(addr_d)];
    end
  end

  // Core bytes are assigned last so they override a same-word preload.
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr[AW-1:0]] <= init_data;
    if (core_we && resetn) begin
      for (int b = 0; b < 4; b++)
        if (wstrb_q[b]) mem[word_idx(addr_q)][b] <= wdata_q[8*b +: 8];
    end
  end

  logic unused;
  assign unused = &{1'b0, init_addr[31:AW]};

  assign mem_ready   = ready_q;
  assign mem_rdata   = rdata_q;
  assign bus_error   = bus_err_q;
  assign proto_error = proto_q;
  assign xfer_count  = xfer_q;
  assign fetch_count = fetch_q;
endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Scoreboard bench for picorv32_mem_responder: random requests against a word-array reference model.
module tb_picorv32_mem_responder;
  localparam int MW = 1024, LAT = 1, MAXW = 7, CW = 4, NW = 64;

  logic clk = 0, resetn = 0, mem_valid = 0, mem_instr = 0, init_we = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, init_addr = 0, init_data = 0;
  logic [3:0] mem_wstrb = 0;
  logic mem_ready, bus_error, proto_error;
  logic [31:0] mem_rdata;
  logic [CW-1:0] xfer_count, fetch_count;

  picorv32_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(32'h0), .LATENCY(LAT), .MAX_WAIT(MAXW),
    .LFSR_SEED(16'hACE1), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .init_we(init_we),
    .init_addr(init_addr), .init_data(init_data), .bus_error(bus_error),
    .proto_error(proto_error), .xfer_count(xfer_count), .fetch_count(fetch_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit is_read; logic [31:0] data; int issue;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  logic [31:0] ref_mem [NW];
  int m_xfer = 0, m_fetch = 0;
  logic m_bus = 0, m_proto = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every mem_ready pops one expectation.
  logic prev_ready = 0;
  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (mem_ready === 1'b1) begin
      chk("ready_single_pulse", 32'(prev_ready), 32'd0);
      if (sb.size() == 0) chk("unexpected_ready", 32'(mem_ready), 32'd0);
      else begin
        e = sb.pop_front();
        lat = cyc - e.issue;
`ifdef PICORV32_MEM_RESPONDER_RANDOM_WAIT_EN
        tests++;
        if (lat < 1 || lat > 1 + MAXW) begin
          fails++;
          $display("FAIL latency_range: got %0d allowed 1..%0d", lat, 1 + MAXW);
        end
`else
        chk("latency", 32'(lat), 32'(1 + LAT));
`endif
        if (e.is_read) chk("rdata", mem_rdata, e.data);
      end
    end
    prev_ready <= mem_ready;
  end

  task automatic preload(input int idx, input logic [31:0] d);
    init_we = 1; init_addr = idx; init_data = d;
    @(posedge clk); #1;
    init_we = 0;
    if (idx < NW) ref_mem[idx] = d;
  endtask

  // Issue one request; collide asserts a same-word preload in the commit cycle.
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit ins, input bit collide, input logic [31:0] cdata);
    exp_t e;
    bit err;
    int idx, n;
    logic [31:0] base;
    err = (a[1:0] != 0) || (a >= MW * 4);
    idx = a / 4;
    e.is_read = (s == 0);
    e.issue = cyc;
    if (err) e.data = 32'hDEAD_BEEF;
    else if (s == 0) e.data = ref_mem[idx];
    else begin
      base = collide ? cdata : ref_mem[idx];
      for (int b = 0; b < 4; b++) if (s[b]) base[8*b +: 8] = d[8*b +: 8];
      ref_mem[idx] = base;
      e.data = 0;
    end
    sb.push_back(e);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    n = 0;
    do begin @(negedge clk); n++; end while (mem_ready !== 1'b1 && n < 40);
    if (mem_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL ready_timeout: no mem_ready after %0d cycles", n);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    if (collide) begin init_we = 1; init_addr = idx; init_data = cdata; end
    @(posedge clk); #1;
    mem_valid = 0; init_we = 0;
    m_xfer++;
    if (ins) m_fetch++;
    if (err) m_bus = 1;
    chk("xfer_count", 32'(xfer_count), 32'(m_xfer % 16));
    chk("fetch_count", 32'(fetch_count), 32'(m_fetch % 16));
    chk("bus_error", 32'(bus_error), 32'(m_bus));
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state();
    chk("rst_ready", 32'(mem_ready), 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_bus_error", 32'(bus_error), 0);
    chk("rst_proto_error", 32'(proto_error), 0);
    chk("rst_xfer", 32'(xfer_count), 0);
    chk("rst_fetch", 32'(fetch_count), 0);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    resetn = 1;
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) preload(i, $urandom);
    preload(4, 32'h1234_5678);

    req(32'h10, 0, 4'b0000, 0, 0, 0);
    req(32'h10, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
    req(32'h10, 0, 4'b0000, 0, 0, 0);
    req(32'h0000_1002, 0, 4'b0000, 1, 0, 0);
    // Preload and core write hitting the same word in the same cycle.
    req(32'h20, 32'h1111_2222, 4'b1001, 0, 1, 32'h5566_7788);
    req(32'h20, 0, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'h1000 + 4 * $urandom_range(0, 255);
      else if (r == 1) a = 4 * $urandom_range(0, NW - 1) + $urandom_range(1, 3);
      else a = 4 * $urandom_range(0, NW - 1);
      if ($urandom_range(0, 1) == 1)
        req(a, $urandom, 4'($urandom_range(1, 15)), 0, (r > 1) && ($urandom_range(0, 7) == 0), $urandom);
      else
        req(a, 0, 4'b0000, 1'($urandom_range(0, 1)), 0, 0);
    end

`ifndef PICORV32_MEM_RESPONDER_RANDOM_WAIT_EN
    // Withdraw a request while it waits: must complete nothing.
    mem_valid = 1; mem_addr = 32'h10; mem_wstrb = 0; mem_instr = 1;
    @(posedge clk); #1;
    mem_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    m_proto = 1;
    chk("proto_error", 32'(proto_error), 32'(m_proto));
    chk("proto_xfer_unchanged", 32'(xfer_count), 32'(m_xfer % 16));
`endif

    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    resetn = 1;
    m_xfer = 0; m_fetch = 0; m_bus = 0; m_proto = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) req(4 * $urandom_range(0, NW - 1), 0, 4'b0000, 1, 0, 0);
    chk("wrap_xfer", 32'(xfer_count), 0);
    chk("wrap_fetch", 32'(fetch_count), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
